// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter and the core that uses it.
package mips_mem_pkg;

   // Default bus widths, also used by the core.
   localparam int unsigned MIPS_ADDR_W = 32;
   localparam int unsigned MIPS_DATA_W = 32;

   // Arbiter sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   // Which port owns the current access.
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } arb_gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the IF/DM ports plus the saturating DM streak counter.
// DM wins by default; once MAX_DM_STREAK consecutive DM grants have been
// made while fetch was waiting, the next contested grant goes to IF.
module mem_arb_pick
   import mips_mem_pkg::*;
#(
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_if_req,
   input  logic     i_dm_req,
   input  logic     i_take,
   output arb_gnt_t o_gnt
);

   localparam int unsigned      SW         = $clog2(MAX_DM_STREAK + 1);
   localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DM_STREAK);

   logic [SW-1:0] r_streak;
   logic          w_streak_full;

   // Pick the winner from the live requests and the current streak.
   always_comb begin
      w_streak_full = (r_streak >= STREAK_MAX);
      o_gnt         = GNT_IF;
      if (i_dm_req && !(i_if_req && w_streak_full)) begin
         o_gnt = GNT_DM;
      end
   end

   // Count DM grants that bypassed a waiting fetch; clear otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_streak <= '0;
      end else if (i_take) begin
         if (o_gnt == GNT_DM && i_if_req) begin
            if (!w_streak_full) begin
               r_streak <= r_streak + 1'b1;
            end
         end else begin
            r_streak <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and data
// memory (DM). One access at a time: IDLE -> ISSUE -> WAIT x WAIT_CYCLES ->
// RESP, with a one-cycle ready pulse to the winning port in RESP.
module mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W        = MIPS_ADDR_W,
   parameter int unsigned DATA_W        = MIPS_DATA_W,
   parameter int unsigned WAIT_CYCLES   = 2,
   parameter int unsigned MAX_DM_STREAK = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   // instruction fetch port
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_ready,
   // data memory port
   input  logic                i_dm_req,
   input  logic                i_dm_we,
   input  logic [DATA_W/8-1:0] i_dm_be,
   input  logic [ADDR_W-1:0]   i_dm_addr,
   input  logic [DATA_W-1:0]   i_dm_wdata,
   output logic [DATA_W-1:0]   o_dm_rdata,
   output logic                o_dm_ready,
   // memory side
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [DATA_W/8-1:0] o_mem_be,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   // status
   output logic                o_busy
);

   localparam int unsigned BE_W      = DATA_W / 8;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   arb_state_t          r_state;
   arb_gnt_t            r_gnt;
   logic                r_write;
   logic [3:0]          r_wait_cnt;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [BE_W-1:0]     r_mem_be;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_if_rdata;
   logic [DATA_W-1:0]   r_dm_rdata;
   logic                r_if_ready;
   logic                r_dm_ready;
   logic                r_busy;

   logic                w_any_req;
   logic                w_take;
   arb_gnt_t            w_gnt;

   assign w_any_req = i_if_req | i_dm_req;
   assign w_take    = (r_state == ST_IDLE) && w_any_req;

   mem_arb_pick #(
      .MAX_DM_STREAK (MAX_DM_STREAK)
   ) u_pick (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_if_req (i_if_req),
      .i_dm_req (i_dm_req),
      .i_take   (w_take),
      .o_gnt    (w_gnt)
   );

   // Access sequencer with all memory-side and port-side outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_gnt       <= GNT_IF;
         r_write     <= 1'b0;
         r_wait_cnt  <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_ready  <= 1'b0;
         r_dm_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_if_ready <= 1'b0;
         r_dm_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state  <= ST_ISSUE;
                  r_busy   <= 1'b1;
                  r_mem_en <= 1'b1;
                  r_gnt    <= w_gnt;
                  if (w_gnt == GNT_DM) begin
                     r_write     <= i_dm_we;
                     r_mem_we    <= i_dm_we;
                     r_mem_be    <= i_dm_be;
                     r_mem_addr  <= i_dm_addr;
                     r_mem_wdata <= i_dm_wdata;
                  end else begin
                     // fetch leaves mem_wdata untouched
                     r_write    <= 1'b0;
                     r_mem_we   <= 1'b0;
                     r_mem_be   <= '1;
                     r_mem_addr <= i_if_addr;
                  end
               end
            end
            ST_ISSUE: begin
               r_state    <= ST_WAIT;
               r_mem_en   <= 1'b0;
               r_mem_we   <= 1'b0;
               r_wait_cnt <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (r_wait_cnt == '0) begin
                  r_state <= ST_RESP;
                  if (r_gnt == GNT_IF) begin
                     r_if_rdata <= i_mem_rdata;
                     r_if_ready <= 1'b1;
                  end else begin
                     if (!r_write) begin
                        r_dm_rdata <= i_mem_rdata;
                     end
                     r_dm_ready <= 1'b1;
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_be    = r_mem_be;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_if_rdata  = r_if_rdata;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_if_ready  = r_if_ready;
   assign o_dm_ready  = r_dm_ready;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=2 / MAX_DM_STREAK=2 main
// instance plus a WAIT_CYCLES=1 instance for the short-latency build.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   // main instance signals
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   // WAIT_CYCLES=1 instance signals
   logic        if_req1;
   logic [31:0] if_addr1;
   logic [31:0] if_rdata1;
   logic        if_ready1;
   logic        dm_req1;
   logic        dm_we1;
   logic [3:0]  dm_be1;
   logic [31:0] dm_addr1;
   logic [31:0] dm_wdata1;
   logic [31:0] dm_rdata1;
   logic        dm_ready1;
   logic        mem_en1;
   logic        mem_we1;
   logic [3:0]  mem_be1;
   logic [31:0] mem_addr1;
   logic [31:0] mem_wdata1;
   logic [31:0] mem_rdata1;
   logic        busy1;

   int n_chk = 0;
   int n_err = 0;

   mem_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .WAIT_CYCLES   (2),
      .MAX_DM_STREAK (2)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_rdata  (if_rdata),
      .o_if_ready  (if_ready),
      .i_dm_req    (dm_req),
      .i_dm_we     (dm_we),
      .i_dm_be     (dm_be),
      .i_dm_addr   (dm_addr),
      .i_dm_wdata  (dm_wdata),
      .o_dm_rdata  (dm_rdata),
      .o_dm_ready  (dm_ready),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_be    (mem_be),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy)
   );

   mem_arbiter #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .WAIT_CYCLES   (1),
      .MAX_DM_STREAK (2)
   ) u_dut1 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_if_req    (if_req1),
      .i_if_addr   (if_addr1),
      .o_if_rdata  (if_rdata1),
      .o_if_ready  (if_ready1),
      .i_dm_req    (dm_req1),
      .i_dm_we     (dm_we1),
      .i_dm_be     (dm_be1),
      .i_dm_addr   (dm_addr1),
      .i_dm_wdata  (dm_wdata1),
      .o_dm_rdata  (dm_rdata1),
      .o_dm_ready  (dm_ready1),
      .o_mem_en    (mem_en1),
      .o_mem_we    (mem_we1),
      .o_mem_be    (mem_be1),
      .o_mem_addr  (mem_addr1),
      .o_mem_wdata (mem_wdata1),
      .i_mem_rdata (mem_rdata1),
      .o_busy      (busy1)
   );

   always #5 clk = ~clk;

   // Memory model: data is driven only in the cycle the arbiter should sample.
   logic [31:0] mem [0:255];
   logic [3:0]  lat;
   logic [3:0]  lat1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       lat <= 4'd0;
      else if (mem_en)                  lat <= 4'd1;
      else if (lat != 0 && lat != 15)   lat <= lat + 4'd1;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       lat1 <= 4'd0;
      else if (mem_en1)                 lat1 <= 4'd1;
      else if (lat1 != 0 && lat1 != 15) lat1 <= lat1 + 4'd1;
   end

   assign mem_rdata  = (lat == 4'd2)  ? mem[mem_addr[9:2]]          : 32'hBADBAD00;
   assign mem_rdata1 = (lat1 == 4'd1) ? {16'hC0DE, mem_addr1[15:0]} : 32'hBADBAD00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      logic [31:0] exp_addr;

      rst_n  = 1'b0;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
      if_req1 = 1'b0; if_addr1 = '0;
      dm_req1 = 1'b0; dm_we1 = 1'b0; dm_be1 = '0; dm_addr1 = '0; dm_wdata1 = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[16] = 32'h2402_0005;   // 0x040
      mem[17] = 32'h1111_2222;   // 0x044
      mem[18] = 32'h8C43_0004;   // 0x048
      mem[32] = 32'h1234_5678;   // 0x080
      mem[64] = 32'hAAAA_AAAA;   // 0x100

      // reset state
      @(negedge clk);
      check("rst busy",      32'(busy),     32'd0);
      check("rst mem_en",    32'(mem_en),   32'd0);
      check("rst mem_we",    32'(mem_we),   32'd0);
      check("rst mem_be",    32'(mem_be),   32'd0);
      check("rst mem_addr",  mem_addr,      32'd0);
      check("rst mem_wdata", mem_wdata,     32'd0);
      check("rst readys",    32'({if_ready, dm_ready}), 32'd0);
      check("rst if_rdata",  if_rdata,      32'd0);
      check("rst dm_rdata",  dm_rdata,      32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // IF read only
      if_req = 1'b1; if_addr = 32'h0000_0040;
      step;
      check("if c1 mem_en",   32'(mem_en),   32'd1);
      check("if c1 mem_we",   32'(mem_we),   32'd0);
      check("if c1 mem_be",   32'(mem_be),   32'hF);
      check("if c1 mem_addr", mem_addr,      32'h40);
      check("if c1 busy",     32'(busy),     32'd1);
      step;
      check("if c2 mem_en",   32'(mem_en),   32'd0);
      check("if c2 if_ready", 32'(if_ready), 32'd0);
      step;
      check("if c3 if_ready", 32'(if_ready), 32'd0);
      step;
      check("if c4 if_ready", 32'(if_ready), 32'd1);
      check("if c4 if_rdata", if_rdata,      32'h2402_0005);
      check("if c4 dm_ready", 32'(dm_ready), 32'd0);
      if_req = 1'b0;
      step;
      check("if c5 if_ready", 32'(if_ready), 32'd0);
      check("if c5 busy",     32'(busy),     32'd0);
      check("if c5 if_rdata", if_rdata,      32'h2402_0005);

      // DM read 0x80
      dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h80;
      step;
      check("dmr c1 mem_addr", mem_addr, 32'h80);
      step; step; step;
      check("dmr c4 dm_ready", 32'(dm_ready), 32'd1);
      check("dmr c4 dm_rdata", dm_rdata,      32'h1234_5678);
      check("dmr c4 if_ready", 32'(if_ready), 32'd0);
      dm_req = 1'b0;
      step;

      // DM write 0x100
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
      step;
      check("dmw c1 mem_en",    32'(mem_en), 32'd1);
      check("dmw c1 mem_we",    32'(mem_we), 32'd1);
      check("dmw c1 mem_be",    32'(mem_be), 32'b0011);
      check("dmw c1 mem_wdata", mem_wdata,   32'hDEAD_BEEF);
      check("dmw c1 mem_addr",  mem_addr,    32'h100);
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
      step;
      check("dmw c2 mem_we", 32'(mem_we), 32'd0);
      step; step;
      check("dmw c4 dm_ready", 32'(dm_ready), 32'd1);
      check("dmw c4 dm_rdata", dm_rdata,      32'h1234_5678);
      dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'hF;
      step;
      check("dmw c5 mem_wdata held", mem_wdata, 32'hDEAD_BEEF);
      check("dmw c5 mem_addr held",  mem_addr,  32'h100);

      // read back the partially written word
      dm_req = 1'b1;
      step; step; step; step;
      check("dmrb c4 dm_ready", 32'(dm_ready), 32'd1);
      check("dmrb c4 dm_rdata", dm_rdata,      32'hAAAA_BEEF);
      dm_req = 1'b0;
      step;

      // simultaneous requests: DM first, IF in the next IDLE
      if_req = 1'b1; if_addr = 32'h44;
      dm_req = 1'b1; dm_addr = 32'h80;
      step;
      check("sim c1 mem_addr", mem_addr, 32'h80);
      step; step; step;
      check("sim c4 dm_ready", 32'(dm_ready), 32'd1);
      check("sim c4 if_ready", 32'(if_ready), 32'd0);
      dm_req = 1'b0;
      step;
      check("sim c5 mem_en", 32'(mem_en), 32'd0);
      step;
      check("sim c6 mem_en",   32'(mem_en), 32'd1);
      check("sim c6 mem_addr", mem_addr,    32'h44);
      step; step; step;
      check("sim c9 if_ready", 32'(if_ready), 32'd1);
      check("sim c9 if_rdata", if_rdata,      32'h1111_2222);
      check("sim c9 dm_ready", 32'(dm_ready), 32'd0);
      if_req = 1'b0;
      step;

      // starvation guard: DM, DM, IF, DM, DM, IF
      if_req = 1'b1; if_addr = 32'h48;
      dm_req = 1'b1; dm_addr = 32'h80;
      for (int g = 0; g < 6; g++) begin
         exp_addr = (g % 3 == 2) ? 32'h48 : 32'h80;
         step;
         check($sformatf("starve g%0d mem_en", g),   32'(mem_en), 32'd1);
         check($sformatf("starve g%0d mem_addr", g), mem_addr,    exp_addr);
         step; step; step;
         if (g % 3 == 2) begin
            check($sformatf("starve g%0d ready", g),
                  32'({if_ready, dm_ready}), 32'b10);
         end else begin
            check($sformatf("starve g%0d ready", g),
                  32'({if_ready, dm_ready}), 32'b01);
         end
         if (g == 5) begin
            if_req = 1'b0;
            dm_req = 1'b0;
         end
         step;
      end
      check("starve if_rdata", if_rdata, 32'h8C43_0004);

      // async reset in the middle of an access
      if_req = 1'b1; if_addr = 32'h40;
      step; step;
      #2 rst_n = 1'b0;
      #1;
      check("arst busy",     32'(busy),     32'd0);
      check("arst mem_en",   32'(mem_en),   32'd0);
      check("arst if_ready", 32'(if_ready), 32'd0);
      check("arst mem_addr", mem_addr,      32'd0);
      check("arst if_rdata", if_rdata,      32'd0);
      if_req = 1'b0;
      @(negedge clk);
      #3 rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 6; c++) begin
         step;
         if (if_ready || dm_ready || busy) hits++;
      end
      check("arst no ready after release", 32'(hits), 32'd0);
      if_req = 1'b1; if_addr = 32'h48;
      step;
      check("arst fresh c1 mem_en", 32'(mem_en), 32'd1);
      step; step;
      check("arst fresh c3 if_ready", 32'(if_ready), 32'd0);
      step;
      check("arst fresh c4 if_ready", 32'(if_ready), 32'd1);
      check("arst fresh c4 if_rdata", if_rdata,      32'h8C43_0004);
      if_req = 1'b0;
      step;

      // WAIT_CYCLES=1 instance
      if_req1 = 1'b1; if_addr1 = 32'h20;
      step;
      check("w1 c1 mem_en",   32'(mem_en1), 32'd1);
      check("w1 c1 mem_addr", mem_addr1,    32'h20);
      step;
      check("w1 c2 if_ready", 32'(if_ready1), 32'd0);
      step;
      check("w1 c3 if_ready", 32'(if_ready1), 32'd1);
      check("w1 c3 if_rdata", if_rdata1,      32'hC0DE_0020);
      if_req1 = 1'b0;
      step;
      check("w1 c4 if_ready", 32'(if_ready1), 32'd0);
      check("w1 c4 busy",     32'(busy1),     32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
